// File: rtl/fetch_btb_pkg.sv
// Shared constants, counter encodings and BTB geometry helpers for the fetch stage.
package fetch_btb_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned PC_W        = 32;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    function automatic int unsigned idx_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned entries);
        return PC_W - idx_bits(entries) - 2;
    endfunction

    function automatic ctr_e ctr_inc(input ctr_e c);
        return (c == ST) ? ST : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e ctr_dec(input ctr_e c);
        return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_btb_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, synchronous train/allocate port.
module btb_table
    import fetch_btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] rd_pc,
    output logic            rd_hit,
    output logic [PC_W-1:0] rd_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int unsigned IDX_W = idx_bits(ENTRIES);
    localparam int unsigned TAG_W = tag_bits(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] upd_tag;

    logic             upd_match;
    logic             wr_en_d;
    logic [PC_W-1:0]  wr_target_d;
    ctr_e             wr_ctr_d;

    assign rd_idx  = rd_pc[IDX_W+1:2];
    assign rd_tag  = rd_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

    // Reads see pre-edge contents, so a same-cycle update becomes visible next cycle.
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && (ctr_q[rd_idx] >= WT);
    assign rd_target = target_q[rd_idx];

    always_comb begin
        upd_match   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        wr_en_d     = 1'b0;
        wr_target_d = target_q[upd_idx];
        wr_ctr_d    = ctr_q[upd_idx];
        if (upd_valid) begin
            if (upd_match) begin
                wr_en_d = 1'b1;
                if (upd_taken) begin
                    wr_target_d = upd_target;
                    wr_ctr_d    = ctr_inc(ctr_q[upd_idx]);
                end else begin
                    wr_ctr_d    = ctr_dec(ctr_q[upd_idx]);
                end
            end else if (upd_taken) begin
                wr_en_d     = 1'b1;
                wr_target_d = upd_target;
                wr_ctr_d    = WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_d) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= wr_target_d;
            ctr_q[upd_idx]    <= wr_ctr_d;
        end
    end

endmodule

// File: rtl/fetch_btb.sv
// Instruction-fetch stage: PC register, next-PC selection and BTB-based taken prediction.
module fetch_btb
    import fetch_btb_pkg::*;
#(
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_data,
    output logic [PC_W-1:0] instruction,
    output logic [PC_W-1:0] next_pc,
    output logic            hit,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;

    btb_table #(
        .ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (pc_q),
        .rd_hit    (hit),
        .rd_target (pred_target),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken),
        .upd_target(upd_target)
    );

    assign pc_plus4    = pc_q + PC_W'(INSTR_BYTES);
    assign imem_addr   = pc_q;
    assign instruction = imem_data;
    assign next_pc     = pc_plus4;

    // Redirect outranks stall: a misprediction must flush even a held fetch.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect) begin
            pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (hit) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: doc/fetch_btb.md
Name: fetch_btb

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Holds the program counter and drives the instruction-memory address.
- Predicts taken branches and jumps with a small direct-mapped branch target buffer (BTB) of 2-bit saturating counters.
- Presents instruction, pc+4 and the prediction "hit" flag for IF/ID to capture on the falling clock edge; takes BTB updates and redirects from the EX stage.

Parameters:
- BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit holds PC (load-use stall).
- imem_addr  out  32  instruction-memory address; equals the PC register.
- imem_data  in  32  instruction word returned combinationally by instruction memory.
- instruction  out  32  imem_data passed through to IF/ID.
- next_pc  out  32  PC+4 to IF/ID.
- hit  out  1  BTB predicts taken for the current PC.
- pred_target  out  32  predicted target; valid when hit=1.
- upd_valid  in  1  EX reports a resolved branch or jump this cycle.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  resolved direction.
- upd_target  in  32  resolved target address.
- redirect  in  1  EX detected a misprediction.
- redirect_pc  in  32  correct fetch address.

Behaviour:
- Clock and reset: single clock domain clk; rst is synchronous and active-high.
- Index and tag: IDX = log2(BTB_ENTRIES). Index = pc[IDX+1:2]. Tag = pc[31:IDX+2]. Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Lookup is combinational on the PC register:
  - hit = valid[idx] & (tag[idx]==pc tag) & ctr[idx][1].
  - pred_target = target[idx].
  - next_pc = pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - instruction = imem_data; imem_addr = pc. Zero latency to IF/ID; outputs settle before the falling edge.
- PC update on the rising edge, in priority order:
  1. rst: pc <= RESET_PC; all valid bits cleared. Counters, tags and targets need not be reset.
  2. redirect: pc <= redirect_pc. Overrides stall.
  3. stall: pc holds.
  4. hit: pc <= pred_target.
  5. Otherwise: pc <= pc+4.
- BTB update on the rising edge when upd_valid=1 and rst=0, using the index and tag of upd_pc:
  - Entry valid and tag match:
    - taken: ctr saturating-increments (max 3) and target <= upd_target.
    - not taken: ctr saturating-decrements (min 0); target unchanged.
  - Miss and taken: allocate the entry (overwrites any occupant) with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss and not taken: no change.
- The BTB update is independent of stall; updates are still applied while stalled.
- Same-cycle lookup and update to the same index: the lookup uses the old contents; the new contents are visible from the next cycle (write-after-read).
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, next_pc=RESET_PC+4, hit=0. pred_target is don't-care while hit=0.
- Reset asserted mid-operation: takes effect at the next rising edge regardless of stall, redirect or upd_valid. An update presented in the same cycle is discarded.
- upd_pc and redirect_pc are word-aligned; bits [1:0] are ignored.

Decomposition:
- Shared package:
  - constant INSTR_BYTES = 4.
  - constant PC_W = 32.
  - 2-bit counter encodings: SNT=0, WNT=1, WT=2, ST=3.
  - function computing the BTB index and tag widths from BTB_ENTRIES.
- One sub-module, btb_table: storage array with a combinational read port and a synchronous update port implementing the counter and allocation rules.
- fetch_btb holds the PC register and the next-PC mux.

Test Plan:
- Reset then 4 cycles with no stall: imem_addr sequence is 0, 4, 8, 12; hit=0 throughout; next_pc is always imem_addr+4.
- Stall held at pc=8 for 3 cycles: imem_addr stays 8; on release it goes to 12.
- Training:
  - upd_valid, upd_pc=0x10, taken, target 0x40 → when pc reaches 0x10, hit=1, pred_target=0x40, and the next imem_addr is 0x40.
  - Two not-taken updates at 0x10 → ctr=0 and hit=0 at 0x10.
- Counter saturation: three taken updates at 0x10 leave ctr=3. One not-taken update gives ctr=2, so hit is still 1. A second gives ctr=1 and hit=0.
- Simultaneous events:
  - redirect=1 with redirect_pc=0x200 while stall=1 and hit=1 → next imem_addr is 0x200.
  - Aliasing update with upd_pc=0x10+4*BTB_ENTRIES, taken → replaces the entry, and a lookup at 0x10 then gives hit=0.
- Reset mid-run: rst asserted while pc=0x40 with a valid BTB entry, together with upd_valid → pc=RESET_PC, all entries invalid, and a later lookup at 0x10 gives hit=0.
